// File: rtl/poly_horner_pipe.sv
// Horner-rule polynomial pipeline: one multiply-add stage per degree, valid/ready on both ends.
// Define POLY_HORNER_SAT_EN to clamp each stage instead of wrapping and to report out_sat.
module poly_horner_pipe #(
   parameter int DATA_W = 8,
   parameter int OUT_W  = 16,
   parameter int DEGREE = 3
) (
   input  logic                            clk,
   input  logic                            rst_n,
   input  logic                            in_valid,
   output logic                            in_ready,
   input  logic [DATA_W-1:0]               x_in,
   output logic                            out_valid,
   input  logic                            out_ready,
   output logic [OUT_W-1:0]                result_out,
   input  logic                            coef_wr,
   input  logic [$clog2(DEGREE+1)-1:0]     coef_idx,
   input  logic [DATA_W-1:0]               coef_data,
   output logic                            busy,
   output logic                            coef_err,
   output logic                            out_sat
);

   localparam int FW = OUT_W + DATA_W;

   logic [DATA_W-1:0] coef_q [DEGREE+1];
   logic [DATA_W-1:0] coef_d [DEGREE+1];
   logic [OUT_W-1:0]  acc_q  [DEGREE];
   logic [OUT_W-1:0]  acc_d  [DEGREE];
   logic [DATA_W-1:0] x_q    [DEGREE];
   logic [DATA_W-1:0] x_d    [DEGREE];
   logic [DEGREE-1:0] vld_q, vld_d;
   logic [DEGREE-1:0] sat_q, sat_d;
   logic              coef_err_q, coef_err_d;
   logic              advance, idx_bad, coef_ok;
   logic [OUT_W:0]    red;

   // Returns {saturated, reduced value}.
   function automatic logic [OUT_W:0] reduce(input logic [FW-1:0] f);
`ifdef POLY_HORNER_SAT_EN
      if (|f[FW-1:OUT_W]) return {1'b1, {OUT_W{1'b1}}};
`endif
      return {1'b0, f[OUT_W-1:0]};
   endfunction

   assign advance    = !vld_q[DEGREE-1] || out_ready;
   assign in_ready   = advance && !coef_wr;
   assign busy       = |vld_q;
   assign out_valid  = vld_q[DEGREE-1];
   assign result_out = acc_q[DEGREE-1];
   assign out_sat    = sat_q[DEGREE-1];
   assign coef_err   = coef_err_q;

   always_comb begin
      idx_bad    = int'(coef_idx) > DEGREE;
      coef_ok    = coef_wr && !busy && !idx_bad;
      coef_err_d = coef_wr && (busy || idx_bad);
      coef_d     = coef_q;
      for (int k = 0; k <= DEGREE; k++) begin
         if (coef_ok && int'(coef_idx) == k) coef_d[k] = coef_data;
      end
      vld_d = vld_q;
      acc_d = acc_q;
      x_d   = x_q;
      sat_d = sat_q;
      red   = '0;
      if (advance) begin
         red = reduce(FW'(coef_q[DEGREE]) * FW'(x_in)
                      + FW'(coef_q[DEGREE-1]));
         vld_d[0] = in_valid && in_ready;
         x_d[0]   = x_in;
         acc_d[0] = red[OUT_W-1:0];
         sat_d[0] = red[OUT_W];
         for (int k = 1; k < DEGREE; k++) begin
            red = reduce(FW'(acc_q[k-1]) * FW'(x_q[k-1])
                         + FW'(coef_q[DEGREE-1-k]));
            vld_d[k] = vld_q[k-1];
            x_d[k]   = x_q[k-1];
            acc_d[k] = red[OUT_W-1:0];
            sat_d[k] = sat_q[k-1] | red[OUT_W];
         end
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         coef_q     <= '{default: '0};
         acc_q      <= '{default: '0};
         x_q        <= '{default: '0};
         vld_q      <= '0;
         sat_q      <= '0;
         coef_err_q <= 1'b0;
      end else begin
         coef_q     <= coef_d;
         acc_q      <= acc_d;
         x_q        <= x_d;
         vld_q      <= vld_d;
         sat_q      <= sat_d;
         coef_err_q <= coef_err_d;
      end
   end

endmodule

// File: tb/tb_poly_horner_pipe.sv
// Directed bench for poly_horner_pipe: DEGREE=3 main instance plus DEGREE=1 and DEGREE=2 instances.
module tb_poly_horner_pipe;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic        rst_n;
   logic        in_valid, in_ready, out_valid, out_ready;
   logic [7:0]  x_in, coef_data;
   logic [15:0] result_out;
   logic        coef_wr, busy, coef_err, out_sat;
   logic [1:0]  coef_idx;

   logic        a_in_valid, a_in_ready, a_out_valid, a_out_ready;
   logic [7:0]  a_x, a_data;
   logic [15:0] a_res;
   logic        a_wr, a_busy, a_err, a_sat;
   logic [0:0]  a_idx;

   logic        b_in_valid, b_in_ready, b_out_valid, b_out_ready;
   logic [7:0]  b_x, b_data;
   logic [15:0] b_res;
   logic        b_wr, b_busy, b_err, b_sat;
   logic [1:0]  b_idx;

   int checks = 0;
   int errors = 0;
   logic [15:0] got[$];

   poly_horner_pipe #(.DATA_W(8), .OUT_W(16), .DEGREE(3)) dut (
      .clk(clk), .rst_n(rst_n),
      .in_valid(in_valid), .in_ready(in_ready), .x_in(x_in),
      .out_valid(out_valid), .out_ready(out_ready), .result_out(result_out),
      .coef_wr(coef_wr), .coef_idx(coef_idx), .coef_data(coef_data),
      .busy(busy), .coef_err(coef_err), .out_sat(out_sat));

   poly_horner_pipe #(.DATA_W(8), .OUT_W(16), .DEGREE(1)) dut1 (
      .clk(clk), .rst_n(rst_n),
      .in_valid(a_in_valid), .in_ready(a_in_ready), .x_in(a_x),
      .out_valid(a_out_valid), .out_ready(a_out_ready), .result_out(a_res),
      .coef_wr(a_wr), .coef_idx(a_idx), .coef_data(a_data),
      .busy(a_busy), .coef_err(a_err), .out_sat(a_sat));

   poly_horner_pipe #(.DATA_W(8), .OUT_W(16), .DEGREE(2)) dut2 (
      .clk(clk), .rst_n(rst_n),
      .in_valid(b_in_valid), .in_ready(b_in_ready), .x_in(b_x),
      .out_valid(b_out_valid), .out_ready(b_out_ready), .result_out(b_res),
      .coef_wr(b_wr), .coef_idx(b_idx), .coef_data(b_data),
      .busy(b_busy), .coef_err(b_err), .out_sat(b_sat));

   always @(negedge clk)
      if (rst_n && out_valid && out_ready) got.push_back(result_out);

   task automatic chk(input string tag, input logic [31:0] obs,
                      input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed %0d expected %0d", tag, obs, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic wc(input logic [1:0] i, input logic [7:0] d);
      coef_wr = 1'b1;
      coef_idx = i;
      coef_data = d;
      step();
      coef_wr = 1'b0;
   endtask

   task automatic wait_out(input string tag);
      int n;
      n = 0;
      while (!out_valid && n < 20) begin
         step();
         n++;
      end
      chk(tag, out_valid, 1);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog timeout");
      $fatal(1, "watchdog");
   end

   initial begin
      logic [15:0] exp_bp [6];
      exp_bp = '{16'd4, 16'd10, 16'd26, 16'd58, 16'd112, 16'd194};
      rst_n = 1'b0;
      in_valid = 0; x_in = 0; out_ready = 1;
      coef_wr = 0; coef_idx = 0; coef_data = 0;
      a_in_valid = 0; a_x = 0; a_out_ready = 1;
      a_wr = 0; a_idx = 0; a_data = 0;
      b_in_valid = 0; b_x = 0; b_out_ready = 1;
      b_wr = 0; b_idx = 0; b_data = 0;
      step();
      step();
      chk("rst_valid", out_valid, 0);
      chk("rst_busy", busy, 0);
      chk("rst_result", result_out, 0);
      chk("rst_err", coef_err, 0);
      chk("rst_sat", out_sat, 0);
      rst_n = 1'b1;
      step();
      chk("idle_ready", in_ready, 1);

      // basic
      wc(3, 1); wc(2, 2); wc(1, 3); wc(0, 4);
      chk("load_err", coef_err, 0);
      in_valid = 1; x_in = 2;
      step();
      x_in = 10;
      step();
      in_valid = 0;
      chk("basic_lat", out_valid, 0);
      step();
      chk("basic0_v", out_valid, 1);
      chk("basic0", result_out, 26);
      step();
      chk("basic1_v", out_valid, 1);
      chk("basic1", result_out, 1234);
      step();
      chk("basic_idle", busy, 0);

      // backpressure
      got.delete();
      begin
         int i, cyc, n;
         logic acc, holdp;
         logic [15:0] held;
         i = 0; cyc = 0; holdp = 0; held = 0;
         while (i < 6 && cyc < 40) begin
            out_ready = !(cyc >= 5 && cyc < 9);
            in_valid = 1;
            x_in = 8'(i);
            #1;
            acc = in_ready;
            if (out_valid && !out_ready) begin
               chk("bp_inready", in_ready, 0);
               if (holdp) chk("bp_hold", result_out, held);
               held = result_out;
               holdp = 1;
            end else holdp = 0;
            @(posedge clk);
            #1;
            if (acc) i++;
            cyc++;
         end
         in_valid = 0;
         out_ready = 1;
         n = 0;
         while (busy && n < 30) begin
            step();
            n++;
         end
         chk("bp_drain", busy, 0);
         chk("bp_count", got.size(), 6);
         for (int k = 0; k < 6 && k < got.size(); k++)
            chk($sformatf("bp_out%0d", k), got[k], exp_bp[k]);
      end

      // wrap / saturate
      wc(3, 1); wc(2, 0); wc(1, 0); wc(0, 0);
      in_valid = 1; x_in = 255;
      step();
      in_valid = 0;
      wait_out("wrap_timeout");
`ifdef POLY_HORNER_SAT_EN
      chk("wrap_result", result_out, 65535);
      chk("wrap_sat", out_sat, 1);
`else
      chk("wrap_result", result_out, 767);
      chk("wrap_sat", out_sat, 0);
`endif
      step();

      // coefficient lockout
      wc(2, 2); wc(1, 3); wc(0, 4);
      in_valid = 1; x_in = 3;
      step();
      in_valid = 0;
      coef_wr = 1; coef_idx = 0; coef_data = 9;
      #1;
      chk("lock_inready", in_ready, 0);
      step();
      coef_wr = 0;
      chk("lock_err", coef_err, 1);
      step();
      chk("lock_pulse", coef_err, 0);
      wait_out("lock_timeout");
      chk("lock_result", result_out, 58);
      step();
      in_valid = 1; x_in = 0;
      step();
      in_valid = 0;
      wait_out("lock_c0_timeout");
      chk("lock_c0", result_out, 4);
      step();

      // reset mid-stream
      in_valid = 1; x_in = 1;
      step();
      x_in = 2;
      step();
      x_in = 3;
      step();
      in_valid = 0;
      chk("rs_busy_pre", busy, 1);
      rst_n = 0;
      #1;
      chk("rs_valid", out_valid, 0);
      chk("rs_busy", busy, 0);
      chk("rs_result", result_out, 0);
      step();
      rst_n = 1;
      step();
      in_valid = 1; x_in = 2;
      step();
      in_valid = 0;
      wait_out("rs_timeout");
      chk("rs_zero", result_out, 0);
      step();

      // DEGREE=1
      a_wr = 1; a_idx = 1; a_data = 3;
      step();
      a_idx = 0; a_data = 5;
      step();
      a_wr = 0;
      a_in_valid = 1; a_x = 7;
      #1;
      chk("d1_pre", a_out_valid, 0);
      step();
      a_in_valid = 0;
      chk("d1_valid", a_out_valid, 1);
      chk("d1_result", a_res, 26);

      // DEGREE=2, out-of-range index
      b_wr = 1; b_idx = 2; b_data = 1;
      step();
      b_idx = 1;
      step();
      b_idx = 0;
      step();
      b_idx = 3; b_data = 7;
      step();
      b_wr = 0;
      chk("d2_idx_err", b_err, 1);
      b_in_valid = 1; b_x = 2;
      step();
      b_in_valid = 0;
      chk("d2_err_pulse", b_err, 0);
      step();
      chk("d2_valid", b_out_valid, 1);
      chk("d2_result", b_res, 7);
      step();

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
